// File: rtl/trace_pkg.sv
// Shared types and entry layout for the commit trace buffer.
// Each entry is packed as {pc, rd, we, data}, with data in the low bits.
package trace_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      POST   = 2'd2,
      FROZEN = 2'd3
   } trace_state_t;

   localparam int RD_W = 5;

   function automatic int entry_w(input int xlen);
      return 2 * xlen + RD_W + 1;
   endfunction

   function automatic int we_lsb(input int xlen);
      return xlen;
   endfunction

   function automatic int rd_lsb(input int xlen);
      return xlen + 1;
   endfunction

   function automatic int pc_lsb(input int xlen);
      return xlen + RD_W + 1;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port and one asynchronous read port.
// The frozen head entry is read combinationally straight from the array.
module trace_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 134,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage is deliberately not reset; validity is tracked by count, and a reset
   // here would turn the array into flops instead of RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures WB-stage commits into a circular buffer, with a PC-match trigger and a post-trigger window.
// Once frozen, the buffer drains oldest-first over a valid/ready port.
module commit_trace_buffer
   import trace_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      arm,
   input  logic                      mode_stop,
   input  logic                      trig_en,
   input  logic [XLEN-1:0]           trig_pc,
   input  logic                      commit_valid,
   input  logic [XLEN-1:0]           commit_pc,
   input  logic [RD_W-1:0]           commit_rd,
   input  logic                      commit_we,
   input  logic [XLEN-1:0]           commit_data,
   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic [XLEN-1:0]           rd_pc,
   output logic [RD_W-1:0]           rd_rd,
   output logic                      rd_we,
   output logic [XLEN-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      triggered,
   output logic                      overflow,
   output logic [1:0]                state
);

   localparam int AW     = $clog2(DEPTH);
   localparam int CW     = AW + 1;
   localparam int EW     = entry_w(XLEN);
   localparam int PW     = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
   localparam int WE_LSB = we_lsb(XLEN);
   localparam int RD_LSB = rd_lsb(XLEN);
   localparam int PC_LSB = pc_lsb(XLEN);

   trace_state_t  state_q, state_d;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_q;
   logic [PW-1:0] post_cnt;
   logic          trig_q, ovf_q, stop_q;
   logic          wr_en, pop, clear, set_trig, set_ovf, load_post, dec_post;
   logic          full, match;
   logic [EW-1:0] wr_entry, rd_entry;

   assign full     = (count_q == CW'(DEPTH));
   assign match    = trig_en && (commit_pc == trig_pc);
   assign rd_valid = (state_q == FROZEN) && (count_q != '0);
   assign wr_entry = {commit_pc, commit_rd, commit_we, commit_data};

   // NOTE: every output of this block gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      wr_en     = 1'b0;
      pop       = 1'b0;
      clear     = 1'b0;
      set_trig  = 1'b0;
      set_ovf   = 1'b0;
      load_post = 1'b0;
      dec_post  = 1'b0;
      if (arm) begin
         clear   = 1'b1;
         state_d = ARMED;
      end else begin
         unique case (state_q)
            ARMED, POST: begin
               if (commit_valid) begin
                  if (full && stop_q) begin
                     set_ovf = 1'b1;
                     state_d = FROZEN;
                  end else begin
                     wr_en = 1'b1;
                     if (full) begin
                        pop     = 1'b1;   // wrap mode: the oldest entry is overwritten
                        set_ovf = 1'b1;
                     end
                     if (state_q == ARMED) begin
                        if (match) begin
                           set_trig = 1'b1;
                           if (POST_TRIG == 0) begin
                              state_d = FROZEN;
                           end else begin
                              load_post = 1'b1;
                              state_d   = POST;
                           end
                        end
                     end else begin
                        dec_post = 1'b1;
                        if (post_cnt == PW'(1)) state_d = FROZEN;
                     end
                  end
               end
            end
            FROZEN: begin
               if (count_q == '0) begin
                  state_d = IDLE;
               end else if (rd_ready) begin
                  pop = 1'b1;
                  if (count_q == CW'(1)) state_d = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values, whatever order the statements are written in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         post_cnt <= '0;
         trig_q   <= 1'b0;
         ovf_q    <= 1'b0;
         stop_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            post_cnt <= '0;
            trig_q   <= 1'b0;
            ovf_q    <= 1'b0;
            stop_q   <= mode_stop;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !wr_en) count_q <= count_q - CW'(1);
            if (set_trig) trig_q <= 1'b1;
            if (set_ovf)  ovf_q  <= 1'b1;
            if (load_post)     post_cnt <= PW'(POST_TRIG);
            else if (dec_post) post_cnt <= post_cnt - PW'(1);
         end
      end
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   // Gated so the port reads zero instead of stale or uninitialised storage.
   assign rd_pc     = rd_valid ? rd_entry[PC_LSB +: XLEN] : '0;
   assign rd_rd     = rd_valid ? rd_entry[RD_LSB +: RD_W] : '0;
   assign rd_we     = rd_valid & rd_entry[WE_LSB];
   assign rd_data   = rd_valid ? rd_entry[XLEN-1:0] : '0;
   assign count     = count_q;
   assign triggered = trig_q;
   assign overflow  = ovf_q;
   assign state     = state_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench: three buffer configurations share one stimulus stream and are
// compared every cycle against a queue-based reference model, plus directed scenarios.
module tb_commit_trace_buffer;

   logic        clk, reset, arm, mode_stop, trig_en, commit_valid, commit_we, rd_ready;
   logic [63:0] trig_pc, commit_pc, commit_data;
   logic [4:0]  commit_rd;

   logic        rv [3];
   logic [63:0] rpc [3];
   logic [4:0]  rrd [3];
   logic        rwe [3];
   logic [63:0] rdat [3];
   logic        trg [3];
   logic        ovf [3];
   logic [1:0]  st [3];
   logic [4:0]  cnt_a;
   logic [2:0]  cnt_b, cnt_c;

   commit_trace_buffer #(.XLEN(64), .DEPTH(16), .POST_TRIG(0)) u_a (
      .clk(clk), .reset(reset), .arm(arm), .mode_stop(mode_stop), .trig_en(trig_en),
      .trig_pc(trig_pc), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_rd(commit_rd), .commit_we(commit_we), .commit_data(commit_data),
      .rd_valid(rv[0]), .rd_ready(rd_ready), .rd_pc(rpc[0]), .rd_rd(rrd[0]), .rd_we(rwe[0]),
      .rd_data(rdat[0]), .count(cnt_a), .triggered(trg[0]), .overflow(ovf[0]), .state(st[0]));

   commit_trace_buffer #(.XLEN(64), .DEPTH(4), .POST_TRIG(0)) u_b (
      .clk(clk), .reset(reset), .arm(arm), .mode_stop(mode_stop), .trig_en(trig_en),
      .trig_pc(trig_pc), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_rd(commit_rd), .commit_we(commit_we), .commit_data(commit_data),
      .rd_valid(rv[1]), .rd_ready(rd_ready), .rd_pc(rpc[1]), .rd_rd(rrd[1]), .rd_we(rwe[1]),
      .rd_data(rdat[1]), .count(cnt_b), .triggered(trg[1]), .overflow(ovf[1]), .state(st[1]));

   commit_trace_buffer #(.XLEN(64), .DEPTH(4), .POST_TRIG(2)) u_c (
      .clk(clk), .reset(reset), .arm(arm), .mode_stop(mode_stop), .trig_en(trig_en),
      .trig_pc(trig_pc), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_rd(commit_rd), .commit_we(commit_we), .commit_data(commit_data),
      .rd_valid(rv[2]), .rd_ready(rd_ready), .rd_pc(rpc[2]), .rd_rd(rrd[2]), .rd_we(rwe[2]),
      .rd_data(rdat[2]), .count(cnt_c), .triggered(trg[2]), .overflow(ovf[2]), .state(st[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   // Reference model: one queue of captured entries per configuration, oldest at the front.
   typedef struct {
      logic [63:0] pc;
      logic [4:0]  rd;
      logic        we;
      logic [63:0] data;
   } ent_t;

   ent_t mq [3][$];
   int   m_state [3];
   int   m_post [3];
   bit   m_trig [3];
   bit   m_ovf [3];
   bit   m_stop [3];

   int n_checks = 0;
   int n_errors = 0;

   function automatic int depth_of(input int i);
      return (i == 0) ? 16 : 4;
   endfunction

   function automatic int post_of(input int i);
      return (i == 2) ? 2 : 0;
   endfunction

   function automatic logic [63:0] count_of(input int i);
      case (i)
         0:       return 64'(cnt_a);
         1:       return 64'(cnt_b);
         default: return 64'(cnt_c);
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mq[i].delete();
         m_state[i] = 0;
         m_post[i]  = 0;
         m_trig[i]  = 1'b0;
         m_ovf[i]   = 1'b0;
         m_stop[i]  = 1'b0;
      end
   endtask

   task automatic model_step(input int i);
      ent_t e;
      e.pc = commit_pc; e.rd = commit_rd; e.we = commit_we; e.data = commit_data;
      if (arm) begin
         mq[i].delete();
         m_trig[i]  = 1'b0;
         m_ovf[i]   = 1'b0;
         m_stop[i]  = mode_stop;
         m_post[i]  = 0;
         m_state[i] = 1;
      end else if ((m_state[i] == 1 || m_state[i] == 2) && commit_valid) begin
         if (mq[i].size() == depth_of(i) && m_stop[i]) begin
            m_ovf[i]   = 1'b1;
            m_state[i] = 3;
         end else begin
            if (mq[i].size() == depth_of(i)) begin
               void'(mq[i].pop_front());
               m_ovf[i] = 1'b1;
            end
            mq[i].push_back(e);
            if (m_state[i] == 1) begin
               if (trig_en && commit_pc == trig_pc) begin
                  m_trig[i] = 1'b1;
                  if (post_of(i) == 0) m_state[i] = 3;
                  else begin
                     m_post[i]  = post_of(i);
                     m_state[i] = 2;
                  end
               end
            end else begin
               m_post[i]--;
               if (m_post[i] == 0) m_state[i] = 3;
            end
         end
      end else if (m_state[i] == 3 && mq[i].size() != 0 && rd_ready) begin
         void'(mq[i].pop_front());
         if (mq[i].size() == 0) m_state[i] = 0;
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         ent_t h;
         logic ev;
         ev = (m_state[i] == 3) && (mq[i].size() != 0);
         h.pc = '0; h.rd = '0; h.we = 1'b0; h.data = '0;
         if (ev) h = mq[i][0];
         check($sformatf("u%0d.state", i),     64'(st[i]),   64'(m_state[i]));
         check($sformatf("u%0d.count", i),     count_of(i),  64'(mq[i].size()));
         check($sformatf("u%0d.triggered", i), 64'(trg[i]),  64'(m_trig[i]));
         check($sformatf("u%0d.overflow", i),  64'(ovf[i]),  64'(m_ovf[i]));
         check($sformatf("u%0d.rd_valid", i),  64'(rv[i]),   64'(ev));
         check($sformatf("u%0d.rd_pc", i),     rpc[i],       h.pc);
         check($sformatf("u%0d.rd_rd", i),     64'(rrd[i]),  64'(h.rd));
         check($sformatf("u%0d.rd_we", i),     64'(rwe[i]),  64'(h.we));
         check($sformatf("u%0d.rd_data", i),   rdat[i],      h.data);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      #1;
      check_all();
   endtask

   task automatic set_idle();
      arm = 1'b0; commit_valid = 1'b0; rd_ready = 1'b0;
      commit_pc = '0; commit_rd = '0; commit_we = 1'b0; commit_data = '0;
   endtask

   task automatic do_arm(input logic stop);
      mode_stop = stop;
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_commit(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] data);
      commit_valid = 1'b1; commit_pc = pc; commit_rd = rd; commit_we = 1'b1; commit_data = data;
      tick();
      commit_valid = 1'b0;
   endtask

   task automatic pop_one();
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b1;
   endtask

   typedef struct {
      logic        arm;
      logic        cv;
      logic [63:0] pc;
      logic [4:0]  rd;
      logic [63:0] data;
      logic        rdy;
      logic [1:0]  e_state;
      int          e_count;
      logic        e_trig;
      logic        e_rv;
      logic [63:0] e_pc;
      logic [63:0] e_data;
   } vec_t;

   vec_t vecs [8];

   initial begin
      // Capture three commits, freeze on the third, then drain them in order.
      vecs[0] = '{1'b1, 1'b0, 64'h0, 5'd0, 64'd0,  1'b0, 2'd1, 0, 1'b0, 1'b0, 64'h0, 64'd0};
      vecs[1] = '{1'b0, 1'b1, 64'h0, 5'd1, 64'd10, 1'b0, 2'd1, 1, 1'b0, 1'b0, 64'h0, 64'd0};
      vecs[2] = '{1'b0, 1'b1, 64'h4, 5'd2, 64'd20, 1'b0, 2'd1, 2, 1'b0, 1'b0, 64'h0, 64'd0};
      vecs[3] = '{1'b0, 1'b1, 64'h8, 5'd3, 64'd30, 1'b0, 2'd3, 3, 1'b1, 1'b1, 64'h0, 64'd10};
      vecs[4] = '{1'b0, 1'b0, 64'h0, 5'd0, 64'd0,  1'b1, 2'd3, 2, 1'b1, 1'b1, 64'h4, 64'd20};
      vecs[5] = '{1'b0, 1'b0, 64'h0, 5'd0, 64'd0,  1'b1, 2'd3, 1, 1'b1, 1'b1, 64'h8, 64'd30};
      vecs[6] = '{1'b0, 1'b0, 64'h0, 5'd0, 64'd0,  1'b1, 2'd0, 0, 1'b1, 1'b0, 64'h0, 64'd0};
      vecs[7] = '{1'b0, 1'b0, 64'h0, 5'd0, 64'd0,  1'b0, 2'd0, 0, 1'b1, 1'b0, 64'h0, 64'd0};

      reset = 1'b0;
      set_idle();
      mode_stop = 1'b0; trig_en = 1'b0; trig_pc = '0;
      model_reset();
      #2;
      check("reset state", 64'(st[0]), 64'd0);
      check("reset count", count_of(0), 64'd0);
      check("reset rd_valid", 64'(rv[0]), 64'd0);
      check_all();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // T1: table-driven capture and drain on the 16-deep, freeze-on-trigger buffer.
      trig_en = 1'b1; trig_pc = 64'h8; mode_stop = 1'b0; commit_we = 1'b1;
      for (int v = 0; v < 8; v++) begin
         arm = vecs[v].arm; commit_valid = vecs[v].cv; commit_pc = vecs[v].pc;
         commit_rd = vecs[v].rd; commit_data = vecs[v].data; rd_ready = vecs[v].rdy;
         tick();
         check($sformatf("T1[%0d] state", v),     64'(st[0]),  64'(vecs[v].e_state));
         check($sformatf("T1[%0d] count", v),     count_of(0), 64'(vecs[v].e_count));
         check($sformatf("T1[%0d] triggered", v), 64'(trg[0]), 64'(vecs[v].e_trig));
         check($sformatf("T1[%0d] rd_valid", v),  64'(rv[0]),  64'(vecs[v].e_rv));
         check($sformatf("T1[%0d] rd_pc", v),     rpc[0],      vecs[v].e_pc);
         check($sformatf("T1[%0d] rd_data", v),   rdat[0],     vecs[v].e_data);
      end
      set_idle();

      // T2: 4-deep wrap; seven commits keep only the newest four.
      trig_en = 1'b1; trig_pc = 64'h18;
      do_arm(1'b0);
      for (int k = 0; k < 7; k++) do_commit(64'(4 * k), 5'(k + 1), 64'(16'h100 + k));
      check("T2 count", 64'(cnt_b), 64'd4);
      check("T2 overflow", 64'(ovf[1]), 64'd1);
      check("T2 state", 64'(st[1]), 64'd3);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("T2 rd_pc[%0d]", k), rpc[1], 64'(12 + 4 * k));
         pop_one();
      end
      check("T2 drained state", 64'(st[1]), 64'd0);
      check("T2 drained rd_valid", 64'(rv[1]), 64'd0);

      // T3: 4-deep stop mode; the fifth commit is dropped and freezes the buffer.
      trig_en = 1'b0;
      do_arm(1'b1);
      for (int k = 0; k < 5; k++) begin
         do_commit(64'(4 * k), 5'(k), 64'(16'h200 + k));
         if (k == 3) check("T3 full still armed", 64'(st[1]), 64'd1);
      end
      check("T3 count", 64'(cnt_b), 64'd4);
      check("T3 overflow", 64'(ovf[1]), 64'd1);
      check("T3 state", 64'(st[1]), 64'd3);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("T3 rd_pc[%0d]", k), rpc[1], 64'(4 * k));
         pop_one();
      end
      check("T3 drained state", 64'(st[1]), 64'd0);

      // T4: two-commit post-trigger window, then T5 backpressure on the frozen result.
      trig_en = 1'b1; trig_pc = 64'h10;
      do_arm(1'b0);
      do_commit(64'h10, 5'd4, 64'h20);
      check("T4 post state", 64'(st[2]), 64'd2);
      check("T4 triggered", 64'(trg[2]), 64'd1);
      do_commit(64'h14, 5'd5, 64'h28);
      check("T4 still post", 64'(st[2]), 64'd2);
      do_commit(64'h18, 5'd6, 64'h30);
      check("T4 frozen", 64'(st[2]), 64'd3);
      do_commit(64'h1C, 5'd7, 64'h38);
      check("T4 ignored count", 64'(cnt_c), 64'd3);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("T5 rd_valid", 64'(rv[2]), 64'd1);
         check("T5 rd_pc", rpc[2], 64'h10);
         check("T5 rd_data", rdat[2], 64'h20);
         check("T5 count", 64'(cnt_c), 64'd3);
      end
      for (int k = 0; k < 3; k++) begin
         check($sformatf("T4 rd_pc[%0d]", k), rpc[2], 64'(16 + 4 * k));
         pop_one();
      end
      check("T4 drained state", 64'(st[2]), 64'd0);

      // T6: reset in the middle of a readout, then arm and commit in the same cycle.
      trig_pc = 64'h8;
      do_arm(1'b0);
      for (int k = 0; k < 3; k++) do_commit(64'(4 * k), 5'(k), 64'(k));
      pop_one();
      reset = 1'b0;
      #1;
      model_reset();
      check("T6 reset state", 64'(st[0]), 64'd0);
      check("T6 reset count", count_of(0), 64'd0);
      check("T6 reset rd_valid", 64'(rv[0]), 64'd0);
      check("T6 reset rd_pc", rpc[0], 64'd0);
      check("T6 reset triggered", 64'(trg[0]), 64'd0);
      check_all();
      @(posedge clk);
      #1;
      reset = 1'b1;
      arm = 1'b1; mode_stop = 1'b0;
      commit_valid = 1'b1; commit_pc = 64'h40; commit_rd = 5'd1; commit_data = 64'h1;
      tick();
      set_idle();
      check("T6 arm+commit count", count_of(0), 64'd0);
      check("T6 arm+commit state", 64'(st[0]), 64'd1);
      do_commit(64'h44, 5'd0, 64'h2);
      check("T6 next commit count", count_of(0), 64'd1);

      // Randomised traffic against the reference model.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 999) == 0) begin
            set_idle();
            do_reset();
         end else begin
            arm          = ($urandom_range(0, 39) == 0);
            mode_stop    = 1'($urandom_range(0, 1));
            trig_en      = ($urandom_range(0, 3) != 0);
            trig_pc      = 64'(4 * $urandom_range(0, 15));
            commit_valid = 1'($urandom_range(0, 1));
            commit_pc    = 64'(4 * $urandom_range(0, 15));
            commit_rd    = 5'($urandom_range(0, 31));
            commit_we    = 1'($urandom_range(0, 1));
            commit_data  = {$urandom, $urandom};
            rd_ready     = ($urandom_range(0, 2) != 0);
            tick();
         end
      end
      set_idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
